// File: rtl/tdm_demux1to4.sv
// Receive side of a 4-channel TDM link: deinterleaves a rotating-slot serial line into four WIDTH-bit words.
// Optional frame-sync misalignment checking and re-alignment is enabled by defining SYNC_CHECK_EN.
module tdm_demux1to4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ip,
  input  logic                 frmSync,
  output logic [4*WIDTH-1:0]   op,
  output logic                 vld,
  output logic [1:0]           sOp,
  output logic                 lock,
  output logic                 syncErr
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [CW-1:0]           bcnt_q, bcnt_d;
  logic [3:0][WIDTH-1:0]   sh_q, sh_d;
  logic [4*WIDTH-1:0]      op_q, op_d;
  logic                    vld_q, vld_d;
  logic                    serr_q, serr_d;
  logic                    resync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    op_d    = op_q;
    vld_d   = 1'b0;
    serr_d  = 1'b0;
    resync  = 1'b0;
`ifdef SYNC_CHECK_EN
    resync  = (state_q == LOCK) && en && frmSync && (slot_q != 2'd0);
`else
    resync  = 1'b0;
`endif
    if (en) begin
      if (state_q == HUNT) begin
        if (frmSync) begin
          sh_d[0] = {sh_q[0][WIDTH-2:0], ip};
          slot_d  = 2'd1;
          bcnt_d  = '0;
          state_d = LOCK;
        end
      end else if (resync) begin
        // Misplaced sync restarts the set: this bit becomes ch0's MSB.
        sh_d       = '0;
        sh_d[0][0] = ip;
        slot_d     = 2'd1;
        bcnt_d     = '0;
        serr_d     = 1'b1;
      end else begin
        sh_d[slot_q] = {sh_q[slot_q][WIDTH-2:0], ip};
        slot_d       = slot_q + 2'd1;
        if (slot_q == 2'd3) begin
          if (bcnt_q == CW'(WIDTH - 1)) begin
            bcnt_d = '0;
            op_d   = sh_d;
            vld_d  = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign op      = op_q;
  assign vld     = vld_q;
  assign sOp     = slot_q;
  assign lock    = (state_q == LOCK);
  assign syncErr = serr_q;

endmodule
